// File: rtl/vanilla_remote_response_tracker_pkg.sv
// rtl/vanilla_remote_response_tracker_pkg.sv - shared types for the remote response tracker
package vanilla_remote_response_tracker_pkg;

    // Entry timestamps are stored at this width; cycle_width_p must not exceed it.
    localparam int rrt_ts_width_gp = 64;

    typedef enum logic [1:0] {
        e_rrt_group         = 2'd0,
        e_rrt_global        = 2'd1,
        e_rrt_dram          = 2'd2,
        e_rrt_dmem_overflow = 2'd3
    } rrt_class_e;

    typedef enum logic [1:0] {
        e_rrt_err_none           = 2'd0,
        e_rrt_err_clear_no_entry = 2'd1,
        e_rrt_err_double_issue   = 2'd2
    } rrt_err_e;

    typedef struct packed {
        logic                       valid;
        rrt_class_e                 cls;
        logic [rrt_ts_width_gp-1:0] ts;
    } rrt_entry_s;

endpackage

// File: rtl/vanilla_rrt_stat_accum.sv
// rtl/vanilla_rrt_stat_accum.sv - saturating count/sum/max of up to two latencies per cycle
module vanilla_rrt_stat_accum #(
    parameter int cycle_width_p = 32,
    parameter int count_width_p = 32,
    parameter int sum_width_p   = 48
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     a_v_i,
    input  logic [cycle_width_p-1:0] a_lat_i,
    input  logic                     b_v_i,
    input  logic [cycle_width_p-1:0] b_lat_i,
    output logic [count_width_p-1:0] count_o,
    output logic [sum_width_p-1:0]   sum_o,
    output logic [cycle_width_p-1:0] max_o
);

    // Two guard bits absorb the worst case of adding two operands before saturating.
    localparam int cw_lp = count_width_p + 2;
    localparam int sw_lp = ((sum_width_p > cycle_width_p) ? sum_width_p : cycle_width_p) + 2;

    logic [count_width_p-1:0] count_r;
    logic [sum_width_p-1:0]   sum_r;
    logic [cycle_width_p-1:0] max_r;

    logic [cw_lp-1:0]         count_wide;
    logic [sw_lp-1:0]         sum_wide;
    logic [cycle_width_p-1:0] a_lat, b_lat, max_n;

    always_comb begin
        a_lat      = a_v_i ? a_lat_i : '0;
        b_lat      = b_v_i ? b_lat_i : '0;
        count_wide = cw_lp'(count_r) + cw_lp'(a_v_i) + cw_lp'(b_v_i);
        sum_wide   = sw_lp'(sum_r) + sw_lp'(a_lat) + sw_lp'(b_lat);
        max_n      = max_r;
        if (a_lat > max_n) max_n = a_lat;
        if (b_lat > max_n) max_n = b_lat;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
            sum_r   <= '0;
            max_r   <= '0;
        end else begin
            count_r <= (count_wide > cw_lp'({count_width_p{1'b1}})) ? '1 : count_wide[count_width_p-1:0];
            sum_r   <= (sum_wide > sw_lp'({sum_width_p{1'b1}})) ? '1 : sum_wide[sum_width_p-1:0];
            max_r   <= max_n;
        end
    end

    assign count_o = count_r;
    assign sum_o   = sum_r;
    assign max_o   = max_r;

endmodule

// File: rtl/vanilla_remote_response_tracker.sv
// rtl/vanilla_remote_response_tracker.sv - matches remote-load issues to scoreboard clears and reports latency
module vanilla_remote_response_tracker
    import vanilla_remote_response_tracker_pkg::*;
#(
    parameter int cycle_width_p    = 32,
    parameter int count_width_p    = 32,
    parameter int sum_width_p      = 48,
    parameter int reg_addr_width_p = 5
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              issue_v_i,
    input  logic                              issue_float_i,
    input  logic [reg_addr_width_p-1:0]       issue_rd_i,
    input  logic [1:0]                        issue_class_i,
    input  logic                              int_sb_clear_i,
    input  logic [reg_addr_width_p-1:0]       int_sb_clear_id_i,
    input  logic                              float_sb_clear_i,
    input  logic [reg_addr_width_p-1:0]       float_sb_clear_id_i,
    input  logic [1:0]                        stat_class_i,
    output logic [1:0]                        done_v_o,
    output logic [1:0][cycle_width_p-1:0]     done_lat_o,
    output logic [1:0][1:0]                   done_class_o,
    output logic [count_width_p-1:0]          stat_count_o,
    output logic [sum_width_p-1:0]            stat_sum_o,
    output logic [cycle_width_p-1:0]          stat_max_o,
    output logic [6:0]                        outstanding_o,
    output logic                              error_o,
    output logic [1:0]                        error_code_o
);

    localparam int regs_lp = 2 ** reg_addr_width_p;

    logic [cycle_width_p-1:0] now_r;
    rrt_entry_s               tab_r [2][regs_lp];
    rrt_entry_s               tab_n [2][regs_lp];

    // Lane 0 is the int file, lane 1 the float file; int x0 is hardwired and never tracked.
    logic [1:0]                  clr_v, iss_v, clr_hit, clr_miss, dbl;
    logic [reg_addr_width_p-1:0] clr_id [2];
    logic [cycle_width_p-1:0]    clr_lat [2];
    rrt_class_e                  clr_cls [2];
    logic [6:0]                  outstanding_n;

    assign clr_v[0]  = int_sb_clear_i && (int_sb_clear_id_i != '0);
    assign clr_v[1]  = float_sb_clear_i;
    assign clr_id[0] = int_sb_clear_id_i;
    assign clr_id[1] = float_sb_clear_id_i;
    assign iss_v[0]  = issue_v_i && !issue_float_i && (issue_rd_i != '0);
    assign iss_v[1]  = issue_v_i && issue_float_i;

    // The clear is applied before the issue so a same-cycle reissue reports the old entry.
    always_comb begin
        tab_n    = tab_r;
        clr_hit  = '0;
        clr_miss = '0;
        dbl      = '0;
        for (int l = 0; l < 2; l++) begin
            clr_lat[l] = now_r - tab_r[l][clr_id[l]].ts[cycle_width_p-1:0];
            clr_cls[l] = tab_r[l][clr_id[l]].cls;
            clr_hit[l]  = clr_v[l] && tab_r[l][clr_id[l]].valid;
            clr_miss[l] = clr_v[l] && !tab_r[l][clr_id[l]].valid;
            if (clr_hit[l]) tab_n[l][clr_id[l]].valid = 1'b0;
            dbl[l] = iss_v[l] && tab_n[l][issue_rd_i].valid;
            if (iss_v[l]) begin
                tab_n[l][issue_rd_i].valid = 1'b1;
                tab_n[l][issue_rd_i].cls   = rrt_class_e'(issue_class_i);
                tab_n[l][issue_rd_i].ts    = rrt_ts_width_gp'(now_r);
            end
        end
    end

    always_comb begin
        outstanding_n = '0;
        for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < regs_lp; r++) begin
                outstanding_n = outstanding_n + 7'(tab_n[l][r].valid);
            end
        end
    end

    logic [1:0]               done_v_r;
    logic [cycle_width_p-1:0] done_lat_r [2];
    rrt_class_e               done_cls_r [2];
    logic [6:0]               outstanding_r;
    logic                     error_r;
    rrt_err_e                 err_code_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            now_r         <= '0;
            tab_r         <= '{default: '0};
            done_v_r      <= '0;
            done_lat_r    <= '{default: '0};
            done_cls_r    <= '{default: e_rrt_group};
            outstanding_r <= '0;
            error_r       <= 1'b0;
            err_code_r    <= e_rrt_err_none;
        end else begin
            now_r         <= now_r + 1'b1;
            tab_r         <= tab_n;
            done_v_r      <= clr_hit;
            done_lat_r    <= clr_lat;
            done_cls_r    <= clr_cls;
            outstanding_r <= outstanding_n;
            if (!error_r) begin
                if (|clr_miss) begin
                    error_r    <= 1'b1;
                    err_code_r <= e_rrt_err_clear_no_entry;
                end else if (|dbl) begin
                    error_r    <= 1'b1;
                    err_code_r <= e_rrt_err_double_issue;
                end
            end
        end
    end

    logic [count_width_p-1:0] stat_count [4];
    logic [sum_width_p-1:0]   stat_sum   [4];
    logic [cycle_width_p-1:0] stat_max   [4];

    for (genvar c = 0; c < 4; c++) begin : g_class
        vanilla_rrt_stat_accum #(
            .cycle_width_p(cycle_width_p),
            .count_width_p(count_width_p),
            .sum_width_p  (sum_width_p)
        ) accum (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .a_v_i  (clr_hit[0] && (clr_cls[0] == rrt_class_e'(c))),
            .a_lat_i(clr_lat[0]),
            .b_v_i  (clr_hit[1] && (clr_cls[1] == rrt_class_e'(c))),
            .b_lat_i(clr_lat[1]),
            .count_o(stat_count[c]),
            .sum_o  (stat_sum[c]),
            .max_o  (stat_max[c])
        );
    end

    assign stat_count_o    = stat_count[stat_class_i];
    assign stat_sum_o      = stat_sum[stat_class_i];
    assign stat_max_o      = stat_max[stat_class_i];
    assign done_v_o        = done_v_r;
    assign done_lat_o[0]   = done_lat_r[0];
    assign done_lat_o[1]   = done_lat_r[1];
    assign done_class_o[0] = done_cls_r[0];
    assign done_class_o[1] = done_cls_r[1];
    assign outstanding_o   = outstanding_r;
    assign error_o         = error_r;
    assign error_code_o    = err_code_r;

endmodule

// File: tb/tb_vanilla_remote_response_tracker.sv
// tb/tb_vanilla_remote_response_tracker.sv - directed bench for vanilla_remote_response_tracker
module tb_vanilla_remote_response_tracker;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_v, issue_float;
    logic [4:0]      issue_rd;
    logic [1:0]      issue_class;
    logic            int_sb_clear, float_sb_clear;
    logic [4:0]      int_sb_clear_id, float_sb_clear_id;
    logic [1:0]      stat_class;
    logic [1:0]      done_v;
    logic [1:0][7:0] done_lat;
    logic [1:0][1:0] done_class;
    logic [3:0]      stat_count;
    logic [7:0]      stat_sum;
    logic [7:0]      stat_max;
    logic [6:0]      outstanding;
    logic            error;
    logic [1:0]      error_code;

    int n_cmp = 0;
    int n_err = 0;
    int t     = 0;

    always #5 clk = ~clk;

    vanilla_remote_response_tracker #(
        .cycle_width_p   (8),
        .count_width_p   (4),
        .sum_width_p     (8),
        .reg_addr_width_p(5)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .issue_v_i          (issue_v),
        .issue_float_i      (issue_float),
        .issue_rd_i         (issue_rd),
        .issue_class_i      (issue_class),
        .int_sb_clear_i     (int_sb_clear),
        .int_sb_clear_id_i  (int_sb_clear_id),
        .float_sb_clear_i   (float_sb_clear),
        .float_sb_clear_id_i(float_sb_clear_id),
        .stat_class_i       (stat_class),
        .done_v_o           (done_v),
        .done_lat_o         (done_lat),
        .done_class_o       (done_class),
        .stat_count_o       (stat_count),
        .stat_sum_o         (stat_sum),
        .stat_max_o         (stat_max),
        .outstanding_o      (outstanding),
        .error_o            (error),
        .error_code_o       (error_code)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic step(input logic iv, input logic f, input logic [4:0] rd, input logic [1:0] c,
                        input logic ic, input logic [4:0] iid, input logic fc, input logic [4:0] fid);
        issue_v = iv; issue_float = f; issue_rd = rd; issue_class = c;
        int_sb_clear = ic; int_sb_clear_id = iid;
        float_sb_clear = fc; float_sb_clear_id = fid;
        tick();
        issue_v = 0; issue_float = 0; issue_rd = 0; issue_class = 0;
        int_sb_clear = 0; int_sb_clear_id = 0; float_sb_clear = 0; float_sb_clear_id = 0;
    endtask

    task automatic issue(input logic f, input logic [4:0] rd, input logic [1:0] c);
        step(1, f, rd, c, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
        t = 0;
    endtask

    initial begin
        reset = 1; stat_class = 0;
        issue_v = 0; issue_float = 0; issue_rd = 0; issue_class = 0;
        int_sb_clear = 0; int_sb_clear_id = 0; float_sb_clear = 0; float_sb_clear_id = 0;
        tick();
        do_reset();
        chk("rst_done_v", done_v, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_error", error, 0);
        chk("rst_code", error_code, 0);
        stat_class = 2; #1;
        chk("rst_count", stat_count, 0);

        // int dram x5: issue at t=10, clear at t=52
        idle(10 - t);
        issue(0, 5, 2);
        chk("t1_outstanding", outstanding, 1);
        idle(52 - t);
        step(0, 0, 0, 0, 1, 5, 0, 0);
        chk("t1_time", t, 53);
        chk("t1_done_v", done_v, 2'b01);
        chk("t1_lat", done_lat[0], 42);
        chk("t1_class", done_class[0], 2);
        chk("t1_count", stat_count, 1);
        chk("t1_sum", stat_sum, 42);
        chk("t1_max", stat_max, 42);
        chk("t1_outstanding0", outstanding, 0);
        tick();
        chk("t1_done_pulse", done_v, 0);

        // float f3 global, same-cycle clear+reissue as group
        issue(1, 3, 1);
        idle(19);
        step(1, 1, 3, 0, 0, 0, 1, 3);
        chk("t2_done_v", done_v, 2'b10);
        chk("t2_lat_a", done_lat[1], 20);
        chk("t2_class_a", done_class[1], 1);
        chk("t2_outstanding", outstanding, 1);
        idle(6);
        step(0, 0, 0, 0, 0, 0, 1, 3);
        chk("t2_lat_b", done_lat[1], 7);
        chk("t2_class_b", done_class[1], 0);
        chk("t2_error", error, 0);
        stat_class = 1; #1;
        chk("t2_glob_count", stat_count, 1);
        chk("t2_glob_sum", stat_sum, 20);

        // both lanes group in one cycle: int lat 11, float lat 10
        issue(0, 7, 0);
        issue(1, 7, 0);
        idle(9);
        step(0, 0, 0, 0, 1, 7, 1, 7);
        chk("t3_done_v", done_v, 2'b11);
        chk("t3_lat0", done_lat[0], 11);
        chk("t3_lat1", done_lat[1], 10);
        stat_class = 0; #1;
        chk("t3_count", stat_count, 3);
        chk("t3_sum", stat_sum, 28);
        chk("t3_max", stat_max, 11);

        // x0 is ignored, then clear_no_entry, then a double issue that must not change the code
        issue(0, 0, 2);
        chk("t4_x0_outstanding", outstanding, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("t4_x0_done", done_v, 0);
        chk("t4_x0_error", error, 0);
        step(0, 0, 0, 0, 1, 9, 0, 0);
        chk("t4_cne_done", done_v, 0);
        chk("t4_cne_error", error, 1);
        chk("t4_cne_code", error_code, 1);
        issue(0, 4, 1);
        issue(0, 4, 2);
        chk("t4_dbl_code", error_code, 1);
        chk("t4_dbl_outstanding", outstanding, 1);
        idle(4);
        step(0, 0, 0, 0, 1, 4, 0, 0);
        chk("t4_ovw_lat", done_lat[0], 5);
        chk("t4_ovw_class", done_class[0], 2);
        stat_class = 2; #1;
        chk("t4_dram_count", stat_count, 2);
        chk("t4_dram_sum", stat_sum, 47);

        // timestamp wrap: issue at ts 250, clear at ts 4
        while ((t % 256) != 250) tick();
        issue(0, 1, 1);
        idle(9);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("t5_wrap_lat", done_lat[0], 10);
        stat_class = 1; #1;
        chk("t5_glob_count", stat_count, 2);
        chk("t5_glob_sum", stat_sum, 30);
        chk("t5_glob_max", stat_max, 20);

        // 17 completions of lat 20 in dmem_overflow: count and sum saturate
        for (int i = 0; i < 17; i++) begin
            issue(0, 2, 3);
            idle(19);
            step(0, 0, 0, 0, 1, 2, 0, 0);
        end
        stat_class = 3; #1;
        chk("t6_sat_count", stat_count, 15);
        chk("t6_sat_sum", stat_sum, 255);
        chk("t6_max", stat_max, 20);

        // reset with three loads outstanding and a clear pending
        issue(0, 10, 0);
        issue(0, 11, 0);
        issue(1, 12, 0);
        chk("t7_outstanding3", outstanding, 3);
        reset = 1;
        step(0, 0, 0, 0, 1, 10, 0, 0);
        reset = 0;
        t = 0;
        chk("t7_rst_done", done_v, 0);
        chk("t7_rst_outstanding", outstanding, 0);
        chk("t7_rst_error", error, 0);
        chk("t7_rst_count", stat_count, 0);
        chk("t7_rst_sum", stat_sum, 0);
        tick();
        chk("t7_after_done", done_v, 0);
        step(0, 0, 0, 0, 0, 0, 1, 12);
        chk("t7_clr_done", done_v, 0);
        chk("t7_clr_error", error, 1);
        chk("t7_clr_code", error_code, 1);

        // double issue alone, then both errors in one cycle
        do_reset();
        issue(1, 2, 0);
        issue(1, 2, 0);
        chk("t8_dbl_error", error, 1);
        chk("t8_dbl_code", error_code, 2);
        do_reset();
        issue(1, 2, 0);
        step(1, 1, 2, 0, 1, 9, 0, 0);
        chk("t9_prio_code", error_code, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
